// File: rtl/cl_pkg.sv
// Shared constants, state/word-type enums and helpers for the Camera Link frame packer.
package cl_pkg;

  localparam int DATA_W = 80;
  localparam int OUT_W  = 128;
  localparam int LINE_W = 16;

  localparam logic [31:0] SOF_MAGIC = 32'hF4A3_5000;
  localparam logic [31:0] EOF_MAGIC = 32'hF4A3_5E0F;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FRAME = 2'd1,
    SKIP  = 2'd2
  } cl_state_e;

  typedef enum logic [1:0] {
    WT_NONE = 2'd0,
    WT_DATA = 2'd1,
    WT_EOF  = 2'd2,
    WT_SOF  = 2'd3
  } cl_word_e;

  // Saturating increment used by the line and drop counters.
  function automatic logic [LINE_W-1:0] sat_inc(input logic [LINE_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/cl_byte_packer.sv
// Byte accumulator: appends one bus beat per push, hands out full words,
// and pads out the remainder on flush. word/word_valid are combinational
// and describe the word produced by this cycle's push/flush.
module cl_byte_packer
  import cl_pkg::*;
#(
  parameter int IN_W   = DATA_W,
  parameter int WORD_W = OUT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              flush,
  input  logic [IN_W-1:0]   data,
  output logic [WORD_W-1:0] word,
  output logic              word_valid
);

  localparam int IN_B   = IN_W / 8;
  localparam int WORD_B = WORD_W / 8;
  localparam int ACC_B  = WORD_B + IN_B;
  localparam int ACC_W  = ACC_B * 8;
  localparam int FILL_W = $clog2(ACC_B + 1);

  logic [ACC_W-1:0]  acc_q, acc_d, merged;
  logic [FILL_W-1:0] fill_q, fill_d, fill_sum;

  // Merge the incoming beat above the current fill, then emit/shift or pad.
  always_comb begin
    merged     = acc_q | (ACC_W'(data) << {fill_q, 3'b000});
    fill_sum   = fill_q + FILL_W'(IN_B);
    acc_d      = acc_q;
    fill_d     = fill_q;
    word       = '0;
    word_valid = 1'b0;
    if (push) begin
      if (fill_sum >= FILL_W'(WORD_B)) begin
        word       = merged[WORD_W-1:0];
        word_valid = 1'b1;
        acc_d      = merged >> WORD_W;
        fill_d     = fill_sum - FILL_W'(WORD_B);
      end else begin
        acc_d  = merged;
        fill_d = fill_sum;
      end
    end else if (flush && (fill_q != '0)) begin
      // Bytes above the fill are always zero, so the low word is already padded.
      word       = acc_q[WORD_W-1:0];
      word_valid = 1'b1;
      acc_d      = '0;
      fill_d     = '0;
    end
  end

  // Accumulator and fill registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      fill_q <= '0;
    end else begin
      acc_q  <= acc_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/cl_frame_packer.sv
// Camera Link capture stage: frames each image with SOF/EOF words and packs
// pixel bytes into 128-bit FIFO writes, dropping words while the FIFO is full.
//
//   state | meaning
//   IDLE  | waiting for a cl_fval rise
//   FRAME | capturing an enabled frame (SOF issued, EOF pending)
//   SKIP  | frame rose with enable low; ignore input until cl_fval falls
module cl_frame_packer
  import cl_pkg::*;
(
  input  logic              cl_clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              cl_fval,
  input  logic              cl_lval,
  input  logic [DATA_W-1:0] cl_data,
  input  logic              fpga_msg_overflow,
  input  logic              clear_overflow,
  output logic [OUT_W-1:0]  fpga_msg,
  output logic              fpga_msg_valid,
  output logic [31:0]       frame_count,
  output logic              overflow_sticky,
  output logic              busy
);

  logic [1:0]        rst_sync_q;
  logic              rst_n;
  cl_state_e         state_q;
  logic              fval_q, lval_q, eof_pend_q;
  logic [LINE_W-1:0] line_cnt_q, line_cnt_d;
  logic [LINE_W-1:0] drop_cnt_q, drop_cnt_d, drop_base;
  logic [31:0]       frame_count_q;
  logic [OUT_W-1:0]  msg_q, word_d, pk_word;
  logic              msg_valid_q, sticky_q, busy_q;
  logic              fval_rise, fval_fall, start_frame, in_frame;
  logic              push, line_end, end_frame, eof_due, pk_valid;
  logic              emit, drop;
  cl_word_e          sel_d;

  // Reset asserts immediately and releases two cl_clk edges later.
  always_ff @(posedge cl_clk or negedge reset) begin
    if (!reset) rst_sync_q <= '0;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n = rst_sync_q[1];

  cl_byte_packer #(
    .IN_W   (DATA_W),
    .WORD_W (OUT_W)
  ) u_packer (
    .clk        (cl_clk),
    .rst_n      (rst_n),
    .push       (push),
    .flush      (line_end),
    .data       (cl_data),
    .word       (pk_word),
    .word_valid (pk_valid)
  );

  // Edge detection, word selection (DATA/PAD > EOF > SOF) and counter next values.
  always_comb begin
    fval_rise   = cl_fval & ~fval_q;
    fval_fall   = ~cl_fval & fval_q;
    start_frame = (state_q == IDLE) & fval_rise & enable;
    in_frame    = (state_q == FRAME) | start_frame;
    push        = in_frame & cl_fval & cl_lval;
    line_end    = (state_q == FRAME) & lval_q & ~cl_lval;
    end_frame   = (state_q == FRAME) & fval_fall;
    eof_due     = end_frame | eof_pend_q;
    line_cnt_d  = line_end ? sat_inc(line_cnt_q) : line_cnt_q;

    sel_d  = WT_NONE;
    word_d = '0;
    if (pk_valid) begin
      sel_d  = WT_DATA;
      word_d = pk_word;
    end else if (eof_due) begin
      sel_d  = WT_EOF;
      word_d = {EOF_MAGIC, frame_count_q, line_cnt_d, drop_cnt_q, 32'h0};
    end else if (start_frame) begin
      sel_d  = WT_SOF;
      word_d = {SOF_MAGIC, frame_count_q, 64'h0};
    end

    emit       = (sel_d != WT_NONE);
    drop       = emit & fpga_msg_overflow;
    drop_base  = start_frame ? '0 : drop_cnt_q;
    drop_cnt_d = drop ? sat_inc(drop_base) : drop_base;
  end

  // Frame FSM, counters and registered outputs.
  always_ff @(posedge cl_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      fval_q        <= 1'b1;  // a frame already in progress at release is not a rise
      lval_q        <= 1'b0;
      eof_pend_q    <= 1'b0;
      line_cnt_q    <= '0;
      drop_cnt_q    <= '0;
      frame_count_q <= '0;
      msg_q         <= '0;
      msg_valid_q   <= 1'b0;
      sticky_q      <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      fval_q <= cl_fval;
      lval_q <= cl_lval;

      case (state_q)
        IDLE:    if (fval_rise) state_q <= enable ? FRAME : SKIP;
        FRAME:   if (fval_fall) state_q <= IDLE;
        SKIP:    if (fval_fall) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase

      // A PAD that collides with the frame end pushes EOF one cycle later.
      eof_pend_q <= (sel_d == WT_DATA) & eof_due;
      line_cnt_q <= start_frame ? '0 : line_cnt_d;
      drop_cnt_q <= drop_cnt_d;

      msg_valid_q <= emit & ~fpga_msg_overflow;
      if (emit && !fpga_msg_overflow) msg_q <= word_d;

      if (sel_d == WT_EOF) frame_count_q <= frame_count_q + 32'd1;

      if (sel_d == WT_SOF)      busy_q <= 1'b1;
      else if (sel_d == WT_EOF) busy_q <= 1'b0;

      if (drop)                sticky_q <= 1'b1;
      else if (clear_overflow) sticky_q <= 1'b0;
    end
  end

  assign fpga_msg        = msg_q;
  assign fpga_msg_valid  = msg_valid_q;
  assign frame_count     = frame_count_q;
  assign overflow_sticky = sticky_q;
  assign busy            = busy_q;

endmodule
